mul_div_unit: RTL

//  Iterative multiply/divide unit in the execute stage, beside the ALU. Takes the same

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mdu_step.sv | 38 +++
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings carried on the op port
//   state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   MDU_WIDTH / MDU_CNT_W : default operand width and iteration counter width
package mul_div_unit_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   acc      : 2*WIDTH+1 bit working register
//              multiply: {partial product (WIDTH+1), remaining multiplier bits (WIDTH)}
//              divide  : {remainder (WIDTH+1), dividend bits / quotient bits (WIDTH)}
//   operand  : |multiplicand| or |divisor|
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_next : value of acc after this iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Multiply: add the multiplicand when the low multiplier bit is set,
    // then shift the whole accumulator right by one.
    sum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder. The shifted
    // remainder can exceed 2**WIDTH, so the trial subtract is one bit wider
    // and its top bit is the borrow.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = {1'b0, rem_sh} - {2'b00, operand};
    if (is_div) begin
      if (diff[WIDTH+1]) acc_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
      else               acc_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: start at edge E0, WIDTH CALC edges, one FIX edge, so the
// result is in hi/lo (with a one-cycle done pulse) after E(WIDTH+1).
// Handshake: start is accepted on a rising edge only while busy==0; operands
// and op are sampled on that edge only. hi_we/lo_we likewise act only while
// busy==0.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          launch request and operation (MULT/MULTU/DIV/DIVU)
//   data1, data2       multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wdata MTHI/MTLO writes
//   busy               operation in flight
//   done               one-cycle pulse when an operation has written hi/lo
//   div_by_zero        valid with done: divide with zero divisor
//   hi, lo             HI/LO registers
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state, state_next;

  logic [2*WIDTH:0] acc, acc_next;
  logic [WIDTH-1:0] opnd_q;    // |data2| (or raw data2 for unsigned ops)
  logic [WIDTH-1:0] raw1_q;    // data1 as presented, for the divide-by-zero result
  logic [CNT_W-1:0] cnt;
  logic             is_div_q, neg_q, sgn1_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  // Operand preparation at the start edge
  logic             signed_op, is_div, s1, s2;
  logic [WIDTH-1:0] abs1, abs2;

  // Sign correction at the FIX edge
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;
  logic               div0;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_next)
  );

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    s1        = signed_op & data1[WIDTH-1];
    s2        = signed_op & data2[WIDTH-1];
    abs1      = s1 ? -data1 : data1;
    abs2      = s2 ? -data2 : data2;
  end

  always_comb begin
    prod_fix = neg_q  ? -acc[2*WIDTH-1:0]     : acc[2*WIDTH-1:0];
    quo_fix  = neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    rem_fix  = sgn1_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    div0     = is_div_q && (opnd_q == '0);
    if (!is_div_q) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div0) begin
      hi_res = raw1_q;
      lo_res = '1;
    end else begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (cnt == CNT_W'(WIDTH-1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd_q   <= '0;
      raw1_q   <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sgn1_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // An MTHI/MTLO on the start edge still lands; FIX overwrites it later.
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            acc      <= {{(WIDTH+1){1'b0}}, abs1};
            opnd_q   <= abs2;
            raw1_q   <= data1;
            cnt      <= '0;
            is_div_q <= is_div;
            neg_q    <= s1 ^ s2;
            sgn1_q   <= s1;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
          dbz_q  <= div0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
